// File: rtl/response_tx_pkg.sv
// Shared definitions for the response UART transmit path.
// Holds the transmitter FSM state type, the UART line levels and the
// helper that derives clocks-per-bit from clock frequency and baud rate.
// Optional feature macro: RESPONSE_UART_TX_PARITY_EN (adds the PARITY state).
package response_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RESPONSE_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    // Integer division; no fractional baud correction is applied.
    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART transmit engine: FSM, baud counter, bit counter and shift register.
// Frames are 8N1, or 8E1 when RESPONSE_UART_TX_PARITY_EN is defined.
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   load         in   take data into the shift register (only honoured when ready)
//   data         in   byte to transmit
//   ready        out  engine is in IDLE and will accept a load this cycle
//   active_next  out  engine will be outside IDLE on the next cycle
//   tx           out  registered serial line, idle high
module uart_tx_core
    import response_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       active_next,
    output logic       tx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             baud_done;
`ifdef RESPONSE_UART_TX_PARITY_EN
    logic             parity;
`endif

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign ready     = (state == IDLE);
    // Lets the top register busy alongside the state it summarises.
    assign active_next = (state == IDLE) ? load : !((state == STOP) && baud_done);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= UART_IDLE_LEVEL;
`ifdef RESPONSE_UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= UART_IDLE_LEVEL;
                    if (load) begin
                        shift <= data;
`ifdef RESPONSE_UART_TX_PARITY_EN
                        parity <= ^data;
`endif
                        tx    <= UART_START_LEVEL;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef RESPONSE_UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= PARITY;
`else
                            tx    <= UART_STOP_LEVEL;
                            state <= STOP;
`endif
                        end else begin
                            // tx is registered, so present the next bit while shifting.
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`ifdef RESPONSE_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        tx       <= UART_STOP_LEVEL;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    tx <= UART_STOP_LEVEL;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= UART_IDLE_LEVEL;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/response_uart_tx.sv
// Response UART transmitter: buffers the response byte stream in a small
// FIFO and serialises it on the UART TX line (8N1, or 8E1 when the macro
// RESPONSE_UART_TX_PARITY_EN is defined).
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   synchronous active-low reset
//   byte_valid  in   one-cycle strobe qualifying byte_in
//   byte_in     in   response byte to transmit
//   tx          out  UART serial output, idle high
//   busy        out  FIFO non-empty or frame in flight (registered)
//   fifo_level  out  bytes currently buffered
//   overflow    out  sticky: a byte was dropped because the FIFO was full
module response_uart_tx
    import response_tx_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9_600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_in,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_next;
    logic          push;
    logic          pop;
    logic          core_ready;
    logic          core_active_next;

    // Full is judged on the registered level, so a same-cycle pop cannot rescue a push.
    assign push = byte_valid && (fifo_level != LW'(FIFO_DEPTH));
    assign pop  = core_ready && (fifo_level != '0);

    always_comb begin
        level_next = fifo_level;
        if (push && !pop) begin
            level_next = fifo_level + LW'(1);
        end else if (pop && !push) begin
            level_next = fifo_level - LW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= byte_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (byte_valid && !push) begin
                overflow <= 1'b1;
            end
            fifo_level <= level_next;
            busy       <= core_active_next || (level_next != '0);
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (pop),
        .data        (mem[rd_ptr]),
        .ready       (core_ready),
        .active_next (core_active_next),
        .tx          (tx)
    );

endmodule

// File: tb/tb_response_uart_tx.sv
// Self-checking bench for response_uart_tx (CLKS_PER_BIT=10, FIFO_DEPTH=4).
// The reference model keeps the buffered bytes in a queue and derives the
// expected line level from the start cycle of the current frame.
module tb_response_uart_tx;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;
`ifdef RESPONSE_UART_TX_PARITY_EN
    localparam int FL = 11 * CPB;
`else
    localparam int FL = 10 * CPB;
`endif

    logic       clock;
    logic       reset_n;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    response_uart_tx #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [7:0] q[$];
    int         cyc;
    int         fstart;
    bit         factive;
    logic [7:0] fbyte;
    bit         movf;

    int checks;
    int fails;

    function automatic bit inframe(input int c);
        return factive && (c >= fstart) && (c < fstart + FL);
    endfunction

    function automatic logic exp_tx();
        int o;
        if (!inframe(cyc)) return 1'b1;
        o = (cyc - fstart) / CPB;
        if (o == 0) return 1'b0;
        if (o <= 8) return fbyte[o-1];
`ifdef RESPONSE_UART_TX_PARITY_EN
        if (o == 9) return ^fbyte;
`endif
        return 1'b1;
    endfunction

    task automatic check_all();
        logic       e_tx;
        logic       e_busy;
        logic [2:0] e_lvl;
        logic       e_ovf;
        e_tx   = exp_tx();
        e_lvl  = 3'(q.size());
        e_busy = inframe(cyc) || (q.size() != 0);
        e_ovf  = movf;
        checks++;
        assert (tx === e_tx) else begin
            fails++;
            $error("FAIL tx cyc=%0d got %b expected %b", cyc, tx, e_tx);
        end
        checks++;
        assert (fifo_level === e_lvl) else begin
            fails++;
            $error("FAIL fifo_level cyc=%0d got %0d expected %0d", cyc, fifo_level, e_lvl);
        end
        checks++;
        assert (busy === e_busy) else begin
            fails++;
            $error("FAIL busy cyc=%0d got %b expected %b", cyc, busy, e_busy);
        end
        checks++;
        assert (overflow === e_ovf) else begin
            fails++;
            $error("FAIL overflow cyc=%0d got %b expected %b", cyc, overflow, e_ovf);
        end
    endtask

    // One clock: drive inputs, advance model across the edge, check on the falling edge.
    task automatic step(input logic v, input logic [7:0] b, input logic r);
        int sz;
        byte_valid = v;
        byte_in    = b;
        reset_n    = r;
        @(posedge clock);
        if (!r) begin
            q.delete();
            factive = 1'b0;
            movf    = 1'b0;
            cyc     = 0;
        end else begin
            sz = q.size();
            if (!inframe(cyc) && sz > 0) begin
                fbyte   = q.pop_front();
                fstart  = cyc + 1;
                factive = 1'b1;
            end
            if (v) begin
                if (sz < DEPTH) q.push_back(b);
                else movf = 1'b1;
            end
            cyc++;
        end
        @(negedge clock);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        cyc        = 0;
        fstart     = 0;
        factive    = 1'b0;
        movf       = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        reset_n    = 1'b0;

        // Reset held 3 cycles, then quiet line
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        idle(200);

        // Single byte
        step(1'b1, 8'h12, 1'b1);
        idle(FL + 10);

        // Two-byte burst
        step(1'b1, 8'h13, 1'b1);
        step(1'b1, 8'hA5, 1'b1);
        idle(2 * FL + 20);

        // Overflow: sixth byte dropped
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b1);
        idle(5 * (FL + 1) + 20);

        // Reset during DATA bit 3 of 0xFF with two bytes queued
        step(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        idle(43);
        step(1'b0, 8'h00, 1'b0);
        idle(200);

        // Parity-relevant pair (plain frames when parity is off)
        step(1'b1, 8'h07, 1'b1);
        idle(FL + 5);
        step(1'b1, 8'h03, 1'b1);
        idle(FL + 5);

        // Randomized bursts with random gaps
        for (int k = 0; k < 20; k++) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int j = 0; j < n; j++) begin
                step(1'b1, 8'($urandom), 1'b1);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 30)));
            end
            idle(int'($urandom_range(0, 400)));
        end
        idle(6 * (FL + 1));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
